// File: rtl/wave_motion.sv
// wave_motion: frame-rate anchor generator for the scrolling surface wave train.
// A frame divider gates updates. Each update steps waveX left, wrapping it
// modulo the wave spacing, and advances a triangle-wave bob that drives waveY.
// All state changes land on the clock edge after a qualifying frame_tick.
module wave_motion #(
  parameter int X_START   = 640,
  parameter int X_PERIOD  = 64,
  parameter int STEP      = 2,
  parameter int Y_BASE    = 36,
  parameter int Y_AMP     = 6,
  parameter int FRAME_DIV = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               enable,
  output logic signed [11:0] waveX,
  output logic signed [11:0] waveY,
  output logic               wrapped
);

  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(FRAME_DIV - 1);
  localparam logic signed [12:0] STEP13   = 13'(STEP);
  localparam logic signed [12:0] PER13    = 13'(X_PERIOD);
  localparam logic signed [12:0] WRAP_LIM = 13'(X_START - X_PERIOD);
  localparam logic signed [11:0] X_INIT   = 12'(X_START);
  localparam logic signed [11:0] Y_INIT   = 12'(Y_BASE);
  localparam logic [3:0]         AMP      = 4'(Y_AMP);

  localparam logic [0:0] ST_DOWN = 1'b0;
  localparam logic [0:0] ST_UP   = 1'b1;

  logic [CW-1:0]      cnt;
  logic [0:0]         state, state_nxt;
  logic [3:0]         off, off_nxt;
  logic               fire;
  logic signed [12:0] t;
  logic [11:0]        x_nxt;
  logic               wrap_nxt;

  // An update fires on the enabled tick that completes a divider period.
  assign fire = frame_tick & enable & (cnt == CNT_LAST);

  // Horizontal step at 13-bit signed width so the wrap compare cannot overflow.
  always_comb begin
    t        = $signed({waveX[11], waveX}) - STEP13;
    wrap_nxt = (t <= WRAP_LIM);
    x_nxt    = wrap_nxt ? 12'(t + PER13) : t[11:0];
  end

  // Bob state machine: ramp offset up to Y_AMP, then back down to 0.
  always_comb begin
    state_nxt = state;
    off_nxt   = off;
    if (AMP == 4'd0) begin
      state_nxt = ST_DOWN;
      off_nxt   = 4'd0;
    end else if (state == ST_DOWN) begin
      if (off == AMP) begin
        state_nxt = ST_UP;
        off_nxt   = AMP - 4'd1;
      end else begin
        off_nxt = off + 4'd1;
      end
    end else begin
      if (off == 4'd0) begin
        state_nxt = ST_DOWN;
        off_nxt   = 4'd1;
      end else begin
        off_nxt = off - 4'd1;
      end
    end
  end

  // Frame divider: counts enabled ticks, holds while disabled.
  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (frame_tick && enable)
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  // Output and bob registers; wrapped is a single-cycle pulse on updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      waveX   <= X_INIT;
      waveY   <= Y_INIT;
      wrapped <= 1'b0;
      state   <= ST_DOWN;
      off     <= 4'd0;
    end else begin
      wrapped <= fire & wrap_nxt;
      if (fire) begin
        waveX <= x_nxt;
        waveY <= Y_INIT + $signed({8'd0, off_nxt});
        state <= state_nxt;
        off   <= off_nxt;
      end
    end
  end

endmodule

// File: doc/wave_motion.md
Name: wave_motion

Overview:
- Frame-rate position generator for the surface wave train.
- Produces the signed anchor coordinates (waveX, waveY) that the wave renderer consumes each frame to draw the lead wave.
- The renderer derives the following wave at waveX-64, so horizontal motion wraps modulo the 64-pixel spacing and the tiled train scrolls seamlessly.
- Motion combines a leftward scroll with a vertical bob state machine. All updates occur during vertical blank, so coordinates never change mid-frame.

Parameters:
- X_START, 640: initial and maximum waveX (pixels).
- X_PERIOD, 64: wrap span; equals the renderer's wave spacing.
- STEP, 2: pixels moved left per update, 1 ≤ STEP < X_PERIOD.
- Y_BASE, 36: waveY at zero bob offset.
- Y_AMP, 6: peak bob offset in pixels, 0..15.
- FRAME_DIV, 2: frame_ticks per update, ≥ 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse at start of vertical blank.
- enable, input, 1: 1 = motion runs; 0 = freeze.
- waveX, output, 12 signed: wave anchor X, registered.
- waveY, output, 12 signed: wave anchor Y, registered.
- wrapped, output, 1: one-cycle pulse when waveX wrapped on this update.

Behaviour:
- Reset values (rst sampled high on a clk edge):
  - waveX = X_START, waveY = Y_BASE, wrapped = 0.
  - Divider count = 0, bob offset = 0, bob state = DOWN.
  - Reset mid-operation discards all motion state on that edge. rst has priority over frame_tick.
- Divider:
  - On a cycle with frame_tick=1 and enable=1: if count == FRAME_DIV-1, the update fires and count goes to 0; otherwise count increments.
  - frame_tick with enable=0 is ignored. Count, outputs and bob state all hold.
  - FRAME_DIV=1 means every enabled frame_tick fires an update.
- Update latency: the new waveX/waveY/wrapped become visible on the clk edge after the qualifying frame_tick cycle (1-cycle latency).
- X arithmetic:
  - Compute t = waveX - STEP at 13-bit signed width.
  - If t ≤ X_START - X_PERIOD: waveX ← t + X_PERIOD, wrapped ← 1.
  - Otherwise: waveX ← t, wrapped ← 0.
  - Invariant: X_START - X_PERIOD < waveX ≤ X_START at all times.
- wrapped: asserted for exactly one cycle (the update cycle), 0 otherwise.
- Bob FSM (state advances only on updates):
  - DOWN: if offset == Y_AMP → state UP, offset ← Y_AMP-1. Else offset ← offset+1.
  - UP: if offset == 0 → state DOWN, offset ← 1. Else offset ← offset-1.
  - Y_AMP = 0: offset is forced to 0 and state stays DOWN.
  - Full cycle is 2·Y_AMP updates.
- waveY = Y_BASE + offset, zero-extended offset, signed 12-bit result; registered with waveX.
- frame_tick held high for multiple cycles counts once per cycle high. Upstream guarantees single-cycle pulses; no edge detection is required.
- Outputs are never combinational from inputs.

Test Plan:
- Reset + idle: hold rst 2 cycles, release, no ticks → waveX=640, waveY=36, wrapped=0 indefinitely.
- Divider/latency: FRAME_DIV=2, ticks at cycles 10 and 20 → no change after tick 1; waveX=638 and waveY=37 on cycle 21; no earlier change.
- Wrap:
  - STEP=2, FRAME_DIV=1, 31 ticks → waveX=578, wrapped never set.
  - 32nd tick → t=576 ≤ 576 → waveX=640, wrapped=1 for one cycle only.
- Bob: Y_AMP=6, 14 updates → waveY sequence 37,38,39,40,41,42,41,40,39,38,37,36,37,38.
- Freeze: enable=0 across 5 ticks → outputs and divider unchanged. Re-enable with FRAME_DIV=2 → the first tick does not update (count resumes from its held value).
- Reset mid-run: after 9 updates, assert rst on the same cycle as frame_tick → next cycle waveX=640, waveY=36, wrapped=0, bob restarts in DOWN.
